video_timing_gen: RTL and testbench

//  Parametrised, runtime-reconfigurable raster timing generator for the display path.

---
 rtl/video_timing_gen.sv | 274 +++++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Runtime-reconfigurable raster timing generator producing HS/VS/DE,
//            a lead-adjusted pixel request and pixel coordinates. Timing
//            updates are staged and applied only at a frame boundary.
//            Optional test-pattern overlay when VTG_PATTERN_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module video_timing_gen #(
  parameter int   CNT_W    = 12,
  parameter int   DATA_W   = 24,
  parameter int   REQ_LEAD = 1,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   DEF_HS   = 44,
  parameter int   DEF_HB   = 148,
  parameter int   DEF_HD   = 1920,
  parameter int   DEF_HF   = 88,
  parameter int   DEF_VS   = 5,
  parameter int   DEF_VB   = 36,
  parameter int   DEF_VD   = 1080,
  parameter int   DEF_VF   = 4
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              run,
  input  logic [CNT_W-1:0]  cfg_h_sync,
  input  logic [CNT_W-1:0]  cfg_h_back,
  input  logic [CNT_W-1:0]  cfg_h_disp,
  input  logic [CNT_W-1:0]  cfg_h_front,
  input  logic [CNT_W-1:0]  cfg_v_sync,
  input  logic [CNT_W-1:0]  cfg_v_back,
  input  logic [CNT_W-1:0]  cfg_v_disp,
  input  logic [CNT_W-1:0]  cfg_v_front,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] pixel_data,
`ifdef VTG_PATTERN_EN
  input  logic [1:0]        pattern_sel,
`endif
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [DATA_W-1:0] video_rgb,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic              frame_start,
  output logic              line_start
);

  localparam logic [CNT_W+1:0] C_MAX_TOT = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   C_LEAD_W  = (CNT_W+1)'(REQ_LEAD);
  localparam logic [CNT_W-1:0] C_LEAD    = CNT_W'(REQ_LEAD);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEF_HT  = CNT_W'(DEF_HS + DEF_HB + DEF_HD + DEF_HF);
  localparam logic [CNT_W-1:0] C_DEF_VT  = CNT_W'(DEF_VS + DEF_VB + DEF_VD + DEF_VF);

  // Active timing set (front porches are only needed through the totals)
  logic [CNT_W-1:0] r_a_hs, r_a_hb, r_a_hd, r_a_vs, r_a_vb, r_a_vd;
  logic [CNT_W-1:0] r_h_total, r_v_total;
  // Pending timing set
  logic [CNT_W-1:0] r_p_hs, r_p_hb, r_p_hd, r_p_vs, r_p_vb, r_p_vd;
  logic [CNT_W-1:0] r_p_ht, r_p_vt;
  logic             r_pending, r_err;

  logic [CNT_W-1:0] r_h, r_v;
  logic             r_hs, r_vs, r_de, r_req, r_fs, r_ls;
  logic [CNT_W-1:0] r_xpos, r_ypos;

  logic [CNT_W+1:0] w_h_sum, w_v_sum;
  logic [CNT_W:0]   w_h_lead_room;
  logic             w_cfg_ok;
  logic             w_h_last, w_v_last, w_boundary;
  logic [CNT_W-1:0] w_de_h0, w_de_h1, w_rq_h0, w_rq_h1, w_act_v0, w_act_v1;
  logic             w_v_act, w_req_n, w_de_n;
  logic [CNT_W-1:0] w_x_n, w_y_n;

  always_comb begin
    w_h_sum = {2'b00, cfg_h_sync} + {2'b00, cfg_h_back}
            + {2'b00, cfg_h_disp} + {2'b00, cfg_h_front};
    w_v_sum = {2'b00, cfg_v_sync} + {2'b00, cfg_v_back}
            + {2'b00, cfg_v_disp} + {2'b00, cfg_v_front};
    w_h_lead_room = {1'b0, cfg_h_sync} + {1'b0, cfg_h_back};
    w_cfg_ok = (cfg_h_sync != '0) && (cfg_h_back != '0) && (cfg_h_disp != '0)
            && (cfg_h_front != '0) && (cfg_v_sync != '0) && (cfg_v_back != '0)
            && (cfg_v_disp != '0) && (cfg_v_front != '0)
            && (w_h_lead_room >= C_LEAD_W)
            && (w_h_sum <= C_MAX_TOT) && (w_v_sum <= C_MAX_TOT);
  end

  // Idle counters sit at h=0,v=0, which counts as a frame boundary
  assign w_h_last   = (r_h == r_h_total - C_ONE);
  assign w_v_last   = (r_v == r_v_total - C_ONE);
  assign w_boundary = !run || (w_h_last && w_v_last);

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_a_hs    <= CNT_W'(DEF_HS);
      r_a_hb    <= CNT_W'(DEF_HB);
      r_a_hd    <= CNT_W'(DEF_HD);
      r_a_vs    <= CNT_W'(DEF_VS);
      r_a_vb    <= CNT_W'(DEF_VB);
      r_a_vd    <= CNT_W'(DEF_VD);
      r_h_total <= C_DEF_HT;
      r_v_total <= C_DEF_VT;
      r_p_hs    <= CNT_W'(DEF_HS);
      r_p_hb    <= CNT_W'(DEF_HB);
      r_p_hd    <= CNT_W'(DEF_HD);
      r_p_vs    <= CNT_W'(DEF_VS);
      r_p_vb    <= CNT_W'(DEF_VB);
      r_p_vd    <= CNT_W'(DEF_VD);
      r_p_ht    <= C_DEF_HT;
      r_p_vt    <= C_DEF_VT;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= cfg_load && !w_cfg_ok;
      if (w_boundary && r_pending) begin
        r_a_hs    <= r_p_hs;
        r_a_hb    <= r_p_hb;
        r_a_hd    <= r_p_hd;
        r_a_vs    <= r_p_vs;
        r_a_vb    <= r_p_vb;
        r_a_vd    <= r_p_vd;
        r_h_total <= r_p_ht;
        r_v_total <= r_p_vt;
        r_pending <= 1'b0;
      end
      // A load in the apply cycle lands after the old set has moved over
      if (cfg_load && w_cfg_ok) begin
        r_p_hs    <= cfg_h_sync;
        r_p_hb    <= cfg_h_back;
        r_p_hd    <= cfg_h_disp;
        r_p_vs    <= cfg_v_sync;
        r_p_vb    <= cfg_v_back;
        r_p_vd    <= cfg_v_disp;
        r_p_ht    <= w_h_sum[CNT_W-1:0];
        r_p_vt    <= w_v_sum[CNT_W-1:0];
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst || !run) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + C_ONE;
    end else begin
      r_h <= r_h + C_ONE;
    end
  end

  always_comb begin
    w_de_h0  = r_a_hs + r_a_hb;
    w_de_h1  = w_de_h0 + r_a_hd;
    w_rq_h0  = w_de_h0 - C_LEAD;
    w_rq_h1  = w_de_h1 - C_LEAD;
    w_act_v0 = r_a_vs + r_a_vb;
    w_act_v1 = w_act_v0 + r_a_vd;
    w_v_act  = (r_v >= w_act_v0) && (r_v < w_act_v1);
    w_req_n  = w_v_act && (r_h >= w_rq_h0) && (r_h < w_rq_h1);
    w_de_n   = w_v_act && (r_h >= w_de_h0) && (r_h < w_de_h1);
    w_x_n    = w_req_n ? (r_h - w_rq_h0)  : '0;
    w_y_n    = w_req_n ? (r_v - w_act_v0) : '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst || !run) begin
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_de   <= 1'b0;
      r_req  <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
      r_fs   <= 1'b0;
      r_ls   <= 1'b0;
    end else begin
      r_hs   <= (r_h < r_a_hs) ? HS_POL : ~HS_POL;
      r_vs   <= (r_v < r_a_vs) ? VS_POL : ~VS_POL;
      r_de   <= w_de_n;
      r_req  <= w_req_n;
      r_xpos <= w_x_n;
      r_ypos <= w_y_n;
      r_fs   <= (r_h == '0) && (r_v == '0);
      r_ls   <= (r_h == '0);
    end
  end

`ifdef VTG_PATTERN_EN
  localparam int C_CH = DATA_W / 3;

  logic [CNT_W-1:0]  r_x_dly   [REQ_LEAD];
  logic [CNT_W-1:0]  r_y_dly   [REQ_LEAD];
  logic [2:0]        r_bar_dly [REQ_LEAD];
  logic [CNT_W-1:0]  r_bar_cnt;
  logic [2:0]        r_bar_idx;
  logic [CNT_W-1:0]  w_bar_w;
  logic [2:0]        w_bar_rgb;
  logic [C_CH-1:0]   w_grey;
  logic [DATA_W-1:0] w_pat;

  assign w_bar_w = r_a_hd >> 3;

  // Bar index tracks xpos incrementally, avoiding a divider
  always_ff @(posedge pixel_clk) begin
    if (sys_rst || !run || !w_req_n || (w_x_n == '0)) begin
      r_bar_cnt <= '0;
      r_bar_idx <= 3'd0;
    end else if (r_bar_cnt == w_bar_w - C_ONE) begin
      r_bar_cnt <= '0;
      if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_cnt <= r_bar_cnt + C_ONE;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < REQ_LEAD; i++) begin
        r_x_dly[i]   <= '0;
        r_y_dly[i]   <= '0;
        r_bar_dly[i] <= 3'd0;
      end
    end else begin
      r_x_dly[0]   <= r_xpos;
      r_y_dly[0]   <= r_ypos;
      r_bar_dly[0] <= r_bar_idx;
      for (int i = 1; i < REQ_LEAD; i++) begin
        r_x_dly[i]   <= r_x_dly[i-1];
        r_y_dly[i]   <= r_y_dly[i-1];
        r_bar_dly[i] <= r_bar_dly[i-1];
      end
    end
  end

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
  assign w_bar_rgb = {~r_bar_dly[REQ_LEAD-1][1], ~r_bar_dly[REQ_LEAD-1][2],
                      ~r_bar_dly[REQ_LEAD-1][0]};
  assign w_grey    = C_CH'(r_x_dly[REQ_LEAD-1]);

  always_comb begin
    w_pat = pixel_data;
    case (pattern_sel)
      2'd1:    w_pat = {{C_CH{w_bar_rgb[2]}}, {C_CH{w_bar_rgb[1]}}, {C_CH{w_bar_rgb[0]}}};
      2'd2:    w_pat = {3{w_grey}};
      2'd3:    w_pat = (r_x_dly[REQ_LEAD-1][3] ^ r_y_dly[REQ_LEAD-1][3]) ? '1 : '0;
      default: w_pat = pixel_data;
    endcase
  end

  assign video_rgb = r_de ? w_pat : '0;
`else
  assign video_rgb = r_de ? pixel_data : '0;
`endif

  assign cfg_pending = r_pending;
  assign cfg_err     = r_err;
  assign video_hs    = r_hs;
  assign video_vs    = r_vs;
  assign video_de    = r_de;
  assign data_req    = r_req;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;
  assign frame_start = r_fs;
  assign line_start  = r_ls;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// Testbench for video_timing_gen: randomized stimulus, frame-level reference
// model feeding a per-cycle scoreboard.
module tb_video_timing_gen;
  localparam int   CNT_W  = 8;
  localparam int   DATA_W = 12;
  localparam int   LEAD   = 3;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b1;
  localparam int D_HS = 4, D_HB = 6, D_HD = 16, D_HF = 3;
  localparam int D_VS = 2, D_VB = 3, D_VD = 5, D_VF = 2;

  typedef struct { int hs, hb, hd, hf, vs, vb, vd, vf; } tim_t;
  typedef struct packed {
    logic hs, vs, de, req;
    logic [CNT_W-1:0] x, y;
    logic fs, ls, pend, err;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, load = 1'b0;
  logic [CNT_W-1:0] c_hs = '0, c_hb = '0, c_hd = '0, c_hf = '0;
  logic [CNT_W-1:0] c_vs = '0, c_vb = '0, c_vd = '0, c_vf = '0;
  logic [DATA_W-1:0] pdata = '0;
  logic cfg_pending, cfg_err, video_hs, video_vs, video_de, data_req;
  logic frame_start, line_start;
  logic [DATA_W-1:0] video_rgb;
  logic [CNT_W-1:0] pixel_xpos, pixel_ypos;

  video_timing_gen #(
    .CNT_W(CNT_W), .DATA_W(DATA_W), .REQ_LEAD(LEAD), .HS_POL(HS_POL), .VS_POL(VS_POL),
    .DEF_HS(D_HS), .DEF_HB(D_HB), .DEF_HD(D_HD), .DEF_HF(D_HF),
    .DEF_VS(D_VS), .DEF_VB(D_VB), .DEF_VD(D_VD), .DEF_VF(D_VF)
  ) dut (
    .pixel_clk(clk), .sys_rst(rst), .run(run),
    .cfg_h_sync(c_hs), .cfg_h_back(c_hb), .cfg_h_disp(c_hd), .cfg_h_front(c_hf),
    .cfg_v_sync(c_vs), .cfg_v_back(c_vb), .cfg_v_disp(c_vd), .cfg_v_front(c_vf),
    .cfg_load(load), .pixel_data(pdata),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  int   n_total = 0, n_bad = 0, cyc = 0;
  int   n_fs_exp = 0, n_fs_dut = 0, n_err_exp = 0, n_err_dut = 0;
  exp_t q[$];

  // Reference model: one position counter per frame, h/v derived by division
  tim_t m_act, m_pend;
  bit   m_pend_v = 1'b0;
  int   m_pos = 0;

  function automatic bit cfg_valid(input tim_t t);
    int ht = t.hs + t.hb + t.hd + t.hf;
    int vt = t.vs + t.vb + t.vd + t.vf;
    return (t.hs != 0) && (t.hb != 0) && (t.hd != 0) && (t.hf != 0) &&
           (t.vs != 0) && (t.vb != 0) && (t.vd != 0) && (t.vf != 0) &&
           (t.hs + t.hb >= LEAD) && (ht < (1 << CNT_W)) && (vt < (1 << CNT_W));
  endfunction

  function automatic int frame_len();
    return (m_act.hs + m_act.hb + m_act.hd + m_act.hf) *
           (m_act.vs + m_act.vb + m_act.vd + m_act.vf);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    tim_t c;
    int   ht, h, v, y0;
    bit   bnd, act;
    e = '0;
    e.hs = ~HS_POL;
    e.vs = ~VS_POL;
    if (rst) begin
      m_act    = '{D_HS, D_HB, D_HD, D_HF, D_VS, D_VB, D_VD, D_VF};
      m_pend_v = 1'b0;
      m_pos    = 0;
    end else begin
      c  = '{int'(c_hs), int'(c_hb), int'(c_hd), int'(c_hf),
             int'(c_vs), int'(c_vb), int'(c_vd), int'(c_vf)};
      ht = m_act.hs + m_act.hb + m_act.hd + m_act.hf;
      if (run) begin
        h    = m_pos % ht;
        v    = m_pos / ht;
        y0   = m_act.vs + m_act.vb;
        act  = (v >= y0) && (v < y0 + m_act.vd);
        e.hs = (h < m_act.hs) ? HS_POL : ~HS_POL;
        e.vs = (v < m_act.vs) ? VS_POL : ~VS_POL;
        e.de = act && (h >= m_act.hs + m_act.hb) && (h < m_act.hs + m_act.hb + m_act.hd);
        e.req = act && (h >= m_act.hs + m_act.hb - LEAD) &&
                (h < m_act.hs + m_act.hb + m_act.hd - LEAD);
        e.x  = e.req ? CNT_W'(h - (m_act.hs + m_act.hb - LEAD)) : '0;
        e.y  = e.req ? CNT_W'(v - y0) : '0;
        e.fs = (m_pos == 0);
        e.ls = (h == 0);
      end
      bnd   = !run || (m_pos == frame_len() - 1);
      e.err = load && !cfg_valid(c);
      if (bnd && m_pend_v) begin
        m_act    = m_pend;
        m_pend_v = 1'b0;
      end
      if (load && cfg_valid(c)) begin
        m_pend   = c;
        m_pend_v = 1'b1;
      end
      e.pend = m_pend_v;
      m_pos  = bnd ? 0 : m_pos + 1;
    end
    if (e.fs)  n_fs_exp++;
    if (e.err) n_err_exp++;
    q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a full set of registered outputs
  always @(posedge clk) begin
    exp_t e, a;
    logic [DATA_W-1:0] rgb_exp;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {video_hs, video_vs, video_de, data_req, pixel_xpos, pixel_ypos,
           frame_start, line_start, cfg_pending, cfg_err};
      n_total++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL timing cyc=%0d got hs%b vs%b de%b rq%b x%0d y%0d fs%b ls%b pd%b er%b exp hs%b vs%b de%b rq%b x%0d y%0d fs%b ls%b pd%b er%b",
                 cyc, a.hs, a.vs, a.de, a.req, a.x, a.y, a.fs, a.ls, a.pend, a.err,
                 e.hs, e.vs, e.de, e.req, e.x, e.y, e.fs, e.ls, e.pend, e.err);
      end
      rgb_exp = e.de ? pdata : '0;
      n_total++;
      if (video_rgb !== rgb_exp) begin
        n_bad++;
        $display("FAIL rgb cyc=%0d got=%h exp=%h", cyc, video_rgb, rgb_exp);
      end
      if (frame_start === 1'b1) n_fs_dut++;
      if (cfg_err === 1'b1)     n_err_dut++;
    end
  end

  task automatic step();
    @(negedge clk);
    load  = 1'b0;
    pdata = DATA_W'($urandom);
  endtask

  task automatic load_now(input tim_t t);
    c_hs = CNT_W'(t.hs); c_hb = CNT_W'(t.hb); c_hd = CNT_W'(t.hd); c_hf = CNT_W'(t.hf);
    c_vs = CNT_W'(t.vs); c_vb = CNT_W'(t.vb); c_vd = CNT_W'(t.vd); c_vf = CNT_W'(t.vf);
    load = 1'b1;
  endtask

  task automatic do_load(input tim_t t);
    step();
    load_now(t);
  endtask

  task automatic wait_pos(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (m_pos == target) return;
    end
    n_total++;
    n_bad++;
    $display("FAIL wait_pos timeout got=%0d exp=%0d", m_pos, target);
  endtask

  task automatic wait_applied(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (!m_pend_v) return;
    end
    n_total++;
    n_bad++;
    $display("FAIL apply timeout got=pending exp=applied within %0d", limit);
  endtask

  function automatic int rnd_field();
    int r = $urandom_range(0, 15);
    if (r == 0) return 0;
    if (r == 1) return 253;
    return $urandom_range(1, 6);
  endfunction

  initial begin
    tim_t t;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    run = 1'b1;
    repeat (2 * frame_len() + 20) step();

    // Mid-frame reconfiguration
    do_load('{3, 5, 20, 4, 1, 2, 6, 1});
    wait_applied(2000);
    repeat (2 * frame_len() + 7) step();

    // Rejections, and the exact total-width limit on both sides
    do_load('{3, 5, 0, 4, 1, 2, 6, 1});
    do_load('{1, 1, 20, 4, 1, 2, 6, 1});
    do_load('{251, 1, 3, 1, 1, 1, 2, 1});
    do_load('{3, 5, 20, 4, 1, 2, 250, 3});
    do_load('{250, 1, 3, 1, 1, 1, 2, 1});
    wait_applied(2000);
    repeat (frame_len() + 3) step();

    // Load coincident with the boundary: only the following boundary applies it
    wait_pos(frame_len() - 1, 3000);
    load_now('{2, 2, 8, 2, 1, 1, 4, 2});
    repeat (frame_len() + 5) step();
    do_load('{4, 1, 10, 2, 2, 1, 3, 1});
    wait_pos(frame_len() - 1, 3000);
    load_now('{5, 3, 12, 1, 1, 2, 5, 2});
    repeat (3 * frame_len()) step();

    // Mid-frame run drop, idle apply, restart
    wait_pos(frame_len() / 2 + 3, 3000);
    run = 1'b0;
    repeat (4) step();
    do_load('{D_HS, D_HB, D_HD, D_HF, D_VS, D_VB, D_VD, D_VF});
    repeat (3) step();
    run = 1'b1;
    repeat (frame_len() + 10) step();

    // Randomized phase
    for (int i = 0; i < 5000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) run = ~run;
      if ($urandom_range(0, 59) == 0) begin
        t = '{rnd_field(), rnd_field(), rnd_field(), rnd_field(),
              rnd_field(), rnd_field(), rnd_field(), rnd_field()};
        load_now(t);
      end
    end
    step();
    step();

    n_total++;
    if (n_fs_dut != n_fs_exp) begin
      n_bad++;
      $display("FAIL frame_count got=%0d exp=%0d", n_fs_dut, n_fs_exp);
    end
    n_total++;
    if (n_err_dut != n_err_exp) begin
      n_bad++;
      $display("FAIL err_count got=%0d exp=%0d", n_err_dut, n_err_exp);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
